// File: rtl/conv2d_relu_with_mem.sv
// Memory-mapped K x K valid convolution with shift and 0..255 clamp, output written back row-major.
// Latency: K*K + H*W + OUT_H*OUT_W*(K*K+1) + 1 cycles start-to-done; no backpressure, memory is single-cycle and always ready.
module conv2d_relu_with_mem #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATABUS_WIDTH = 32,
    parameter int HEIGHT        = 6,
    parameter int WIDTH         = 6,
    parameter int K             = 3,
    parameter int STRIDE        = 1,
    parameter int OUT_SHIFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     done,
    input  logic [ADDR_WIDTH-1:0]    input_addr,
    input  logic [ADDR_WIDTH-1:0]    weight_addr,
    input  logic [ADDR_WIDTH-1:0]    output_addr,
    output logic                     mem_w,
    output logic                     mem_sel,
    inout  wire  [ADDR_WIDTH-1:0]    address_bus,
    inout  wire  [DATABUS_WIDTH-1:0] data_bus
);

    localparam int OUT_H = (HEIGHT - K) / STRIDE + 1;
    localparam int OUT_W = (WIDTH - K) / STRIDE + 1;
    localparam int KK    = K * K;
    localparam int NPIX  = HEIGHT * WIDTH;
    localparam int CW    = $clog2(NPIX + 1);
    localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int KW    = (KK > 1) ? $clog2(KK) : 1;
    localparam int ACC_W = 2 * DATA_WIDTH + $clog2(KK) + 1;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << DATA_WIDTH) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KERNEL,
        S_LOAD_INPUT,
        S_MAC,
        S_WRITE,
        S_FINISHED
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATABUS_WIDTH-1:0] data_reg;
    logic [CW-1:0]            cnt;
    logic [CW-1:0]            mi, mj, ox, oy;
    logic signed [ACC_W-1:0]  acc;

    logic signed [DATA_WIDTH-1:0] w_mem   [KK];
    logic        [DATA_WIDTH-1:0] pix_mem [NPIX];

    logic                          mac_last, out_last, load_k_last, load_i_last;
    logic [PW-1:0]                 pidx;
    logic [KW-1:0]                 widx;
    logic signed [DATA_WIDTH:0]    pix_s;
    logic signed [DATA_WIDTH-1:0]  w_s;
    logic signed [ACC_W-1:0]       prod, acc_sum, shifted;
    logic [DATA_WIDTH-1:0]         relu_out;
    logic                          addr_drive;
    logic                          unused_hi_bits;

    assign mac_last    = (mi == CW'(K - 1)) && (mj == CW'(K - 1));
    assign out_last    = (ox == CW'(OUT_W - 1)) && (oy == CW'(OUT_H - 1));
    assign load_k_last = (cnt == CW'(KK - 1));
    assign load_i_last = (cnt == CW'(NPIX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:        if (start) state_nxt = S_LOAD_KERNEL;
            S_LOAD_KERNEL: if (load_k_last) state_nxt = S_LOAD_INPUT;
            S_LOAD_INPUT:  if (load_i_last) state_nxt = S_MAC;
            S_MAC:         if (mac_last) state_nxt = S_WRITE;
            S_WRITE:       state_nxt = out_last ? S_FINISHED : S_MAC;
            S_FINISHED:    if (!start) state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    // Window element (oy*STRIDE+mi, ox*STRIDE+mj) and its weight feed one MAC per cycle.
    always_comb begin
        pidx     = PW'((int'(oy) * STRIDE + int'(mi)) * WIDTH + int'(ox) * STRIDE + int'(mj));
        widx     = KW'(int'(mi) * K + int'(mj));
        pix_s    = {1'b0, pix_mem[pidx]};
        w_s      = w_mem[widx];
        prod     = ACC_W'(pix_s) * ACC_W'(w_s);
        acc_sum  = acc + prod;
        shifted  = acc_sum >>> OUT_SHIFT;
        relu_out = shifted[DATA_WIDTH-1:0];
        if (shifted < 0)
            relu_out = '0;
        else if (shifted > MAXV)
            relu_out = '1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done     <= 1'b0;
            mem_w    <= 1'b0;
            mem_sel  <= 1'b0;
            addr     <= '0;
            data_reg <= '0;
            cnt      <= '0;
            mi       <= '0;
            mj       <= '0;
            ox       <= '0;
            oy       <= '0;
            acc      <= '0;
        end else begin
            done <= (state == S_FINISHED);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        mi      <= '0;
                        mj      <= '0;
                        ox      <= '0;
                        oy      <= '0;
                        mem_sel <= 1'b1;
                        mem_w   <= 1'b0;
                        addr    <= weight_addr;
                    end
                end
                S_LOAD_KERNEL: begin
                    if (load_k_last) begin
                        cnt  <= '0;
                        addr <= input_addr;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        addr <= addr + 1'b1;
                    end
                end
                S_LOAD_INPUT: begin
                    if (load_i_last) begin
                        cnt     <= '0;
                        mem_sel <= 1'b0;
                        mem_w   <= 1'b1;
                        addr    <= output_addr;
                        acc     <= '0;
                        mi      <= '0;
                        mj      <= '0;
                        ox      <= '0;
                        oy      <= '0;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        addr <= addr + 1'b1;
                    end
                end
                S_MAC: begin
                    acc <= acc_sum;
                    if (mac_last) begin
                        data_reg <= DATABUS_WIDTH'(relu_out);
                        mem_sel  <= 1'b1;
                        mi       <= '0;
                        mj       <= '0;
                    end else if (mj == CW'(K - 1)) begin
                        mj <= '0;
                        mi <= mi + 1'b1;
                    end else begin
                        mj <= mj + 1'b1;
                    end
                end
                S_WRITE: begin
                    mem_sel <= 1'b0;
                    addr    <= addr + 1'b1;
                    acc     <= '0;
                    if (ox == CW'(OUT_W - 1)) begin
                        ox <= '0;
                        oy <= oy + 1'b1;
                    end else begin
                        ox <= ox + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand storage is rewritten on every job, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == S_LOAD_KERNEL)
            w_mem[cnt[KW-1:0]] <= data_bus[DATA_WIDTH-1:0];
        if (state == S_LOAD_INPUT)
            pix_mem[cnt[PW-1:0]] <= data_bus[DATA_WIDTH-1:0];
    end

    assign addr_drive  = (state == S_LOAD_KERNEL) || (state == S_LOAD_INPUT) || (state == S_WRITE);
    assign address_bus = addr_drive ? addr : 'z;
    assign data_bus    = (state == S_WRITE) ? data_reg : 'z;

    assign unused_hi_bits = ^data_bus[DATABUS_WIDTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_conv2d_relu_with_mem.sv
// Scoreboard bench for conv2d_relu_with_mem: directed jobs, write monitor on the memory bus.
module tb_conv2d_relu_with_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_a = 8'h00, w_a = 8'h00, o_a = 8'h00;

    wire  [7:0]  abus, abus2;
    wire  [31:0] dbus, dbus2;
    logic        done, done2, mw, mw2, ms, ms2;

    logic [31:0] mem  [256];
    logic [31:0] mem2 [256];

    always #5 clk = ~clk;

    assign dbus  = (ms  && !mw)  ? mem[abus]   : 'z;
    assign dbus2 = (ms2 && !mw2) ? mem2[abus2] : 'z;

    conv2d_relu_with_mem u_dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .input_addr(in_a), .weight_addr(w_a), .output_addr(o_a),
        .mem_w(mw), .mem_sel(ms), .address_bus(abus), .data_bus(dbus)
    );

    conv2d_relu_with_mem #(.OUT_SHIFT(11)) u_dut_sh (
        .clk(clk), .rst(rst), .start(start), .done(done2),
        .input_addr(in_a), .weight_addr(w_a), .output_addr(o_a),
        .mem_w(mw2), .mem_sel(ms2), .address_bus(abus2), .data_bus(dbus2)
    );

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t q1[$];
    wr_t q2[$];
    wr_t e1, e2;

    int n_cmp = 0;
    int n_bad = 0;
    int sel_cnt = 0;
    int wr_cnt = 0;
    bit chk2 = 1'b0;

    int ramp_exp[16] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22, 25, 26, 27, 28};

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model and write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (ms) sel_cnt++;
        if (ms && mw) begin
            wr_cnt++;
            mem[abus] = dbus;
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0d data %0d, expected no write", abus, dbus);
            end else begin
                e1 = q1.pop_front();
                check("wr_addr", abus, e1.a);
                check("wr_data", dbus, e1.d);
            end
        end
        if (ms2 && mw2) begin
            mem2[abus2] = dbus2;
            if (chk2) begin
                if (q2.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write_sh: addr %0d data %0d, expected no write", abus2, dbus2);
                end else begin
                    e2 = q2.pop_front();
                    check("wr_addr_sh", abus2, e2.a);
                    check("wr_data_sh", dbus2, e2.d);
                end
            end
        end
    end

    task automatic put(input logic [7:0] a, input logic [7:0] v);
        mem[a]  = {24'hA5C3E1, v};
        mem2[a] = {24'hA5C3E1, v};
    endtask

    task automatic load_k(input logic [7:0] base, input logic [7:0] centre, input logic [7:0] other);
        for (int i = 0; i < 9; i++)
            put(base + 8'(i), (i == 4) ? centre : other);
    endtask

    task automatic load_in(input logic [7:0] base, input bit ramp, input logic [7:0] val);
        for (int i = 0; i < 36; i++)
            put(base + 8'(i), ramp ? 8'((i / 6) * 6 + (i % 6)) : val);
    endtask

    // kind 0: ramp with centre tap, 1: constant, 2: ramp with all-ones kernel
    task automatic push_exp(input logic [7:0] ob, input int kind, input int cval, input int count);
        int v;
        for (int n = 0; n < count; n++) begin
            v = (kind == 0) ? ramp_exp[n] : (kind == 2) ? 9 * ramp_exp[n] : cval;
            q1.push_back('{a: ob + 8'(n), d: 32'(v)});
        end
    endtask

    task automatic run_job(input logic [7:0] wb, input logic [7:0] ib, input logic [7:0] ob, input bit hold);
        int cyc;
        w_a = wb;
        in_a = ib;
        o_a = ob;
        sel_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 400);
        check("done_latency", cyc, 206);
        check("sel_cycles", sel_cnt, 61);
        check("queue_drained", q1.size(), 0);
        if (hold) begin
            repeat (20) @(posedge clk);
            #1;
            check("done_held", done, 1);
            check("no_restart", sel_cnt, 61);
        end
        start = 1'b0;
        cyc = 0;
        while (done && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_cleared", done, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        #12;
        check("rst_done", done, 0);
        check("rst_mem_sel", ms, 0);
        check("rst_mem_w", mw, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_done", done, 0);

        // Centre-tap kernel over a ramp reproduces the inner 4x4 of the input.
        load_k(8'h00, 8'd1, 8'd0);
        load_in(8'h10, 1'b1, 8'd0);
        push_exp(8'h80, 0, 0, 16);
        run_job(8'h00, 8'h10, 8'h80, 1'b0);

        // Constant 10 with all-ones kernel, start held through completion.
        load_k(8'h00, 8'd1, 8'd1);
        load_in(8'h10, 1'b0, 8'd10);
        push_exp(8'h80, 1, 90, 16);
        run_job(8'h00, 8'h10, 8'h80, 1'b1);

        // All -1 weights drive every sum negative.
        load_k(8'h00, 8'hFF, 8'hFF);
        push_exp(8'h80, 1, 0, 16);
        run_job(8'h00, 8'h10, 8'h80, 1'b0);

        // 255 x 127 x 9 = 291465: saturates, and 291465 >>> 11 = 142.
        load_k(8'h00, 8'd127, 8'd127);
        load_in(8'h10, 1'b0, 8'd255);
        push_exp(8'h80, 1, 255, 16);
        for (int n = 0; n < 16; n++)
            q2.push_back('{a: 8'h80 + 8'(n), d: 32'd142});
        chk2 = 1'b1;
        run_job(8'h00, 8'h10, 8'h80, 1'b0);
        chk2 = 1'b0;
        check("queue_drained_sh", q2.size(), 0);

        // Abort during the MAC of output 5.
        load_k(8'h00, 8'd1, 8'd0);
        load_in(8'h10, 1'b1, 8'd0);
        push_exp(8'h80, 0, 0, 5);
        wr_cnt = 0;
        w_a = 8'h00;
        in_a = 8'h10;
        o_a = 8'h80;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (wr_cnt < 5 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("abort_writes_seen", wr_cnt, 5);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_done", done, 0);
        check("abort_mem_sel", ms, 0);
        check("abort_mem_w", mw, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_more_writes", wr_cnt, 5);

        // Fresh job after reset, relocated buffers and wrapping output address.
        load_k(8'h40, 8'd1, 8'd1);
        load_in(8'h50, 1'b1, 8'd0);
        push_exp(8'hF8, 2, 0, 16);
        run_job(8'h40, 8'h50, 8'hF8, 1'b0);
        check("wrapped_word_mem", mem[8'h07] & 32'hFF, 9 * 28);

        check("final_queue_empty", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
